conv_ofm_collector: RTL and testbench
=====================================

Name: conv_ofm_collector

Overview:
- Receiving end of a convolution unit's output stream: takes one result word per valid pulse and writes it into a local output-feature-map (OFM) buffer.
- Sums partial results across several input-depth passes, so a filter split over NUMBER_OF_UNITS units ends up with one OFM plane.
- After the final pass, the buffer becomes readable by the next layer's IFM loader through a registered read port.

Parameters:
- DATA_WIDTH, 32, word width of conv results and OFM entries
- IFM_SIZE, 14, input feature map edge
- KERNAL_SIZE, 5, kernel edge
- IFM_DEPTH, 6, input channels
- NUMBER_OF_UNITS, 3, channels handled per pass
- IFM_SIZE_NEXT, IFM_SIZE-KERNAL_SIZE+1, OFM edge (derived)
- NUM_PASSES, IFM_DEPTH/NUMBER_OF_UNITS, accumulation passes, must be ≥1 (derived)
- OFM_PIXELS, IFM_SIZE_NEXT*IFM_SIZE_NEXT, buffer depth, must be ≥2 (derived)
- ADDRESS_SIZE_OFM, $clog2(OFM_PIXELS), buffer address width (derived)

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-low reset
- start  input  1  one-cycle pulse; begins a new layer at pass 0, pixel 0
- conv_valid  input  1  conv_data carries the next raster-order pixel
- conv_data  input  DATA_WIDTH  convolution result, two's complement
- rd_en  input  1  read request, honoured only in DONE
- rd_addr  input  ADDRESS_SIZE_OFM  OFM read address
- rd_data  output  DATA_WIDTH  registered read data
- busy  output  1  high in ACCUM
- done  output  1  high in DONE
- pass_idx  output  $clog2(NUM_PASSES+1)  current pass number
- err  output  1  sticky flag: conv_valid seen outside ACCUM

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; pixel and pass counters 0; busy=0, done=0, err=0, rd_data=0, pass_idx=0. Buffer contents are undefined.
- FSM states:
  - IDLE: start → ACCUM.
  - ACCUM: after the write of pixel OFM_PIXELS-1 on pass NUM_PASSES-1 commits → DONE. start → restart at pass 0, pixel 0.
  - DONE: start → ACCUM, counters cleared.
- Pixel counter:
  - Increments on each accepted conv_valid.
  - Wraps OFM_PIXELS-1 → 0 and increments pass_idx at the wrap.
- Accumulation pipeline (conv_valid accepted in cycle t for pixel p):
  - Cycle t: buffer read address = p (synchronous read). conv_data and p are registered.
  - Cycle t+1: write to p. Pass 0 writes conv_data. Pass >0 writes old+conv_data.
  - Addition is DATA_WIDTH two's complement and wraps on overflow.
  - The write commits at the edge ending cycle t+1, so write latency is 1 cycle for every pass.
  - conv_valid may assert every cycle; there is no backpressure.
  - OFM_PIXELS≥2 guarantees a pixel is never read while its own write is in flight.
- done rises in the cycle after the final write commits; busy falls in the same cycle.
- Read port:
  - In DONE, rd_en at edge t gives rd_data = OFM[rd_addr] after that edge, i.e. 1-cycle latency.
  - rd_en outside DONE is ignored and rd_data holds its value.
- Simultaneous start and conv_valid: start wins. The conv_valid is dropped and does not set err.
- start mid-ACCUM: any in-flight write still commits. Counters restart at 0, and pass 0 overwrites all pixels.
- conv_valid in IDLE or DONE: ignored, err←1. err clears only on reset or start.
- Asynchronous reset mid-operation: immediately returns to IDLE; any pending write is discarded.

Optional Feature:
- Macro OFM_RELU_EN.
- Defined: on pass NUM_PASSES-1 the value written is max(0, sum), with sum treated as signed. Earlier passes are unaffected.
- Undefined: the raw wrapped sum is written on every pass.

Decomposition:
- Shared package (conv_pkg):
  - state enum {IDLE, ACCUM, DONE}
  - derived constants IFM_SIZE_NEXT, OFM_PIXELS, NUM_PASSES, and the address-width function
- Sub-module: the buffer reuses the team's existing SinglePort_Memory style as a simple dual-port variant, ofm_dp_ram (one synchronous read port, one write port, MEM_SIZE=OFM_PIXELS). Accumulator, counters and FSM stay in the top.

Test Plan:
- IFM_SIZE=6, KERNAL_SIZE=5 (OFM 2x2), NUM_PASSES=2: start; stream 1,2,3,4 then 10,20,30,40 back-to-back → done one cycle after last write; reads of addresses 0..3 return 11,22,33,44 one cycle after each rd_en.
- Same config, gaps of 3 idle cycles between valids → identical results; busy high throughout, pass_idx 0→1→2.
- OFM_RELU_EN defined: pass 0 = 5,-7,0,1; pass 1 = -10,3,0,-2 → reads 0,0,0,0. Undefined → -5,-4,0,-1 (two's complement).
- start asserted after 2 valids of pass 1 → pass_idx=0, busy stays 1; new 4+4 stream produces only the new sums.
- conv_valid while IDLE → err=1, no buffer write; next start → err=0. start coincident with conv_valid → valid dropped, err stays 0.
- reset pulled low mid-pass-1 → busy=0, done=0, rd_data=0 immediately; rd_en in IDLE → rd_data unchanged.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared definitions for the convolution OFM collector.
// Holds FSM state codes and helpers for the derived geometry constants.
package conv_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    function automatic int ofm_edge(input int ifm_size, input int kernel_size);
        return ifm_size - kernel_size + 1;
    endfunction

    function automatic int num_passes(input int depth, input int units);
        return depth / units;
    endfunction

    function automatic int addr_width(input int entries);
        int w;
        w = 0;
        while ((1 << w) < entries) w++;
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/ofm_dp_ram.sv
// Simple dual-port OFM buffer: one write port, one synchronous read port.
// Ports: clk; we/waddr/wdata write side; re/raddr read side, rdata registered.
module ofm_dp_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_SIZE   = 4,
    parameter int ADDR_W     = 2
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [MEM_SIZE];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/conv_ofm_collector.sv
// Collects conv results into an OFM buffer, summing over input-depth passes,
// then exposes the buffer through a 1-cycle read port once the layer is done.
// Ports: clk, reset (async active-low), start, conv_valid/conv_data stream,
// rd_en/rd_addr/rd_data read port, busy, done, pass_idx, sticky err.
// Build option: define OFM_RELU_EN to clamp negative sums to 0 on the last pass.
module conv_ofm_collector
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH       = 32,
    parameter int IFM_SIZE         = 14,
    parameter int KERNAL_SIZE      = 5,
    parameter int IFM_DEPTH        = 6,
    parameter int NUMBER_OF_UNITS  = 3,
    parameter int IFM_SIZE_NEXT    = ofm_edge(IFM_SIZE, KERNAL_SIZE),
    parameter int NUM_PASSES       = num_passes(IFM_DEPTH, NUMBER_OF_UNITS),
    parameter int OFM_PIXELS       = IFM_SIZE_NEXT * IFM_SIZE_NEXT,
    parameter int ADDRESS_SIZE_OFM = addr_width(OFM_PIXELS),
    parameter int PASS_W           = $clog2(NUM_PASSES + 1)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        conv_valid,
    input  logic [DATA_WIDTH-1:0]       conv_data,
    input  logic                        rd_en,
    input  logic [ADDRESS_SIZE_OFM-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0]       rd_data,
    output logic                        busy,
    output logic                        done,
    output logic [PASS_W-1:0]           pass_idx,
    output logic                        err
);

    localparam logic [ADDRESS_SIZE_OFM-1:0] LAST_PIX =
        ADDRESS_SIZE_OFM'(OFM_PIXELS - 1);
    localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(NUM_PASSES - 1);
    localparam logic [PASS_W-1:0] END_PASS  = PASS_W'(NUM_PASSES);

    logic [1:0]                  state;
    logic [ADDRESS_SIZE_OFM-1:0] pix_cnt;
    logic [PASS_W-1:0]           pass_cnt;

    logic                        pend_valid;
    logic [ADDRESS_SIZE_OFM-1:0] pend_addr;
    logic [DATA_WIDTH-1:0]       pend_data;
    logic                        pend_first;
    logic                        pend_last;

    logic                        rd_ld;
    logic [DATA_WIDTH-1:0]       rd_hold;
    logic [DATA_WIDTH-1:0]       ram_q;
    logic [DATA_WIDTH-1:0]       sum;
    logic [DATA_WIDTH-1:0]       wdata;
    logic                        accept;
    logic                        final_commit;
    logic                        ram_re;
    logic [ADDRESS_SIZE_OFM-1:0] ram_raddr;

    // Once the last pixel of the last pass is taken the pass counter sits
    // at NUM_PASSES for one cycle; further valids are not accumulated.
    assign accept = (state == S_ACCUM) && conv_valid && !start &&
                    (pass_cnt != END_PASS);

    assign final_commit = pend_valid && pend_last && (pend_addr == LAST_PIX);

    assign sum = pend_first ? pend_data : ram_q + pend_data;

`ifdef OFM_RELU_EN
    assign wdata = (pend_last && sum[DATA_WIDTH-1]) ? '0 : sum;
`else
    assign wdata = sum;
`endif

    // The single read port serves accumulation in ACCUM and the
    // external reader in DONE.
    assign ram_re    = accept || ((state == S_DONE) && rd_en);
    assign ram_raddr = (state == S_DONE) ? rd_addr : pix_cnt;

    ofm_dp_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_SIZE   (OFM_PIXELS),
        .ADDR_W     (ADDRESS_SIZE_OFM)
    ) u_ram (
        .clk   (clk),
        .we    (pend_valid),
        .waddr (pend_addr),
        .wdata (wdata),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (ram_q)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            pix_cnt    <= '0;
            pass_cnt   <= '0;
            err        <= 1'b0;
            pend_valid <= 1'b0;
            pend_addr  <= '0;
            pend_data  <= '0;
            pend_first <= 1'b0;
            pend_last  <= 1'b0;
            rd_ld      <= 1'b0;
            rd_hold    <= '0;
        end else begin
            pend_valid <= accept;
            if (accept) begin
                pend_addr  <= pix_cnt;
                pend_data  <= conv_data;
                pend_first <= (pass_cnt == '0);
                pend_last  <= (pass_cnt == LAST_PASS);
            end

            if (start) begin
                state    <= S_ACCUM;
                pix_cnt  <= '0;
                pass_cnt <= '0;
                err      <= 1'b0;
            end else begin
                if (conv_valid && (state != S_ACCUM)) err <= 1'b1;
                if (accept) begin
                    if (pix_cnt == LAST_PIX) begin
                        pix_cnt  <= '0;
                        pass_cnt <= pass_cnt + 1'b1;
                    end else begin
                        pix_cnt <= pix_cnt + 1'b1;
                    end
                end
                if ((state == S_ACCUM) && final_commit) state <= S_DONE;
            end

            rd_ld <= (state == S_DONE) && rd_en;
            if (rd_ld) rd_hold <= ram_q;
        end
    end

    // rd_data follows the RAM output register only right after a DONE read;
    // otherwise the last read value is held, so accumulation reads stay hidden.
    assign rd_data  = rd_ld ? ram_q : rd_hold;
    assign busy     = (state == S_ACCUM);
    assign done     = (state == S_DONE);
    assign pass_idx = pass_cnt;

endmodule

// File: tb/tb_conv_ofm_collector.sv
// Self-checking bench for conv_ofm_collector, 2x2 OFM over 2 passes.
// Random streams are checked against a plain array model of the OFM sums.
module tb_conv_ofm_collector;

    localparam int DW   = 32;
    localparam int NPIX = 4;
    localparam int NP   = 2;
    localparam int AW   = 2;
    localparam int PW   = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          conv_valid = 1'b0;
    logic [DW-1:0] conv_data = '0;
    logic          rd_en = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [DW-1:0] rd_data;
    logic          busy;
    logic          done;
    logic [PW-1:0] pass_idx;
    logic          err;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] exp_mem [NPIX];

    conv_ofm_collector #(
        .DATA_WIDTH      (DW),
        .IFM_SIZE        (6),
        .KERNAL_SIZE     (5),
        .IFM_DEPTH       (6),
        .NUMBER_OF_UNITS (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .conv_valid (conv_valid),
        .conv_data  (conv_data),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .busy       (busy),
        .done       (done),
        .pass_idx   (pass_idx),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Reference: sum each pixel over all passes, then clamp if ReLU is built in.
    function automatic void model_layer(input logic [DW-1:0] s[$]);
        logic signed [DW-1:0] acc [NPIX];
        for (int p = 0; p < NPIX; p++) acc[p] = '0;
        for (int i = 0; i < s.size(); i++) begin
            if (i < NPIX) acc[i % NPIX] = s[i];
            else acc[i % NPIX] = acc[i % NPIX] + s[i];
        end
        for (int p = 0; p < NPIX; p++) begin
`ifdef OFM_RELU_EN
            if (acc[p] < 0) acc[p] = '0;
`endif
            exp_mem[p] = acc[p];
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] d);
        conv_valid = 1'b1;
        conv_data  = d;
        tick();
        conv_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic read_word(input int a, output logic [DW-1:0] d);
        rd_en   = 1'b1;
        rd_addr = AW'(a);
        tick();
        rd_en = 1'b0;
        d = rd_data;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags busy=%b done=%b err=%b want 000",
                     busy, done, err);
        end
        checks++;
        if (rd_data !== '0 || pass_idx !== '0) begin
            errors++;
            $display("FAIL reset_data rd_data=%h pass_idx=%0d want 0 0",
                     rd_data, pass_idx);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset busy=%b done=%b want 0 0",
                     busy, done);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] s[$];
        logic [DW-1:0] d;
        s = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd10, 32'd20, 32'd30, 32'd40};
        model_layer(s);
        pulse_start();
        checks++;
        if (busy !== 1'b1 || pass_idx !== '0) begin
            errors++;
            $display("FAIL b2b_start busy=%b pass_idx=%0d want 1 0",
                     busy, pass_idx);
        end
        for (int i = 0; i < s.size(); i++) send(s[i]);
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_pre_done done=%b busy=%b want 0 1",
                     done, busy);
        end
        tick();
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || pass_idx !== PW'(NP)) begin
            errors++;
            $display("FAIL b2b_done done=%b busy=%b pass_idx=%0d want 1 0 2",
                     done, busy, pass_idx);
        end
        for (int a = 0; a < NPIX; a++) begin
            read_word(a, d);
            checks++;
            if (d !== exp_mem[a] || d !== DW'(11 * (a + 1))) begin
                errors++;
                $display("FAIL b2b_read[%0d] got %0d want %0d",
                         a, d, 11 * (a + 1));
            end
        end
    endtask

    task automatic test_relu_signs();
        int vals [8] = '{5, -7, 0, 1, -10, 3, 0, -2};
`ifdef OFM_RELU_EN
        int want [NPIX] = '{0, 0, 0, 0};
`else
        int want [NPIX] = '{-5, -4, 0, -1};
`endif
        logic [DW-1:0] d;
        pulse_start();
        for (int i = 0; i < 8; i++) send(DW'(vals[i]));
        tick();
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL relu_done done=%b want 1", done);
        end
        for (int a = 0; a < NPIX; a++) begin
            read_word(a, d);
            checks++;
            if (d !== DW'(want[a])) begin
                errors++;
                $display("FAIL relu_read[%0d] got %0d want %0d",
                         a, $signed(d), want[a]);
            end
        end
    endtask

    task automatic test_gaps();
        logic [DW-1:0] s[$];
        logic [DW-1:0] d;
        for (int i = 0; i < NP * NPIX; i++) s.push_back($urandom);
        model_layer(s);
        pulse_start();
        for (int i = 0; i < s.size(); i++) begin
            if (i > 0) begin
                for (int g = 0; g < 3; g++) begin
                    checks++;
                    if (busy !== 1'b1) begin
                        errors++;
                        $display("FAIL gap_busy i=%0d busy=%b want 1", i, busy);
                    end
                    tick();
                end
            end
            if (i % NPIX == 0) begin
                checks++;
                if (pass_idx !== PW'(i / NPIX)) begin
                    errors++;
                    $display("FAIL gap_pass i=%0d pass_idx=%0d want %0d",
                             i, pass_idx, i / NPIX);
                end
            end
            send(s[i]);
        end
        tick();
        checks++;
        if (done !== 1'b1 || pass_idx !== PW'(NP)) begin
            errors++;
            $display("FAIL gap_done done=%b pass_idx=%0d want 1 2",
                     done, pass_idx);
        end
        for (int a = 0; a < NPIX; a++) begin
            read_word(a, d);
            checks++;
            if (d !== exp_mem[a]) begin
                errors++;
                $display("FAIL gap_read[%0d] got %h want %h", a, d, exp_mem[a]);
            end
        end
    endtask

    task automatic test_restart();
        logic [DW-1:0] s[$];
        logic [DW-1:0] d;
        logic [DW-1:0] held;
        held = rd_data;
        pulse_start();
        read_word(1, d);
        checks++;
        if (d !== held) begin
            errors++;
            $display("FAIL accum_rd_ignored got %h want %h", d, held);
        end
        for (int i = 0; i < NPIX + 2; i++) send($urandom);
        checks++;
        if (pass_idx !== PW'(1)) begin
            errors++;
            $display("FAIL restart_pre pass_idx=%0d want 1", pass_idx);
        end
        pulse_start();
        checks++;
        if (pass_idx !== '0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL restart_state pass_idx=%0d busy=%b want 0 1",
                     pass_idx, busy);
        end
        for (int i = 0; i < NP * NPIX; i++) s.push_back($urandom);
        model_layer(s);
        for (int i = 0; i < s.size(); i++) send(s[i]);
        tick();
        for (int a = 0; a < NPIX; a++) begin
            read_word(a, d);
            checks++;
            if (d !== exp_mem[a]) begin
                errors++;
                $display("FAIL restart_read[%0d] got %h want %h",
                         a, d, exp_mem[a]);
            end
        end
    endtask

    task automatic test_err();
        logic [DW-1:0] s[$];
        logic [DW-1:0] d;
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_clear_pre err=%b want 0", err);
        end
        send(32'hDEAD_BEEF);
        checks++;
        if (err !== 1'b1 || done !== 1'b1) begin
            errors++;
            $display("FAIL err_done err=%b done=%b want 1 1", err, done);
        end
        for (int a = 0; a < NPIX; a++) begin
            read_word(a, d);
            checks++;
            if (d !== exp_mem[a]) begin
                errors++;
                $display("FAIL err_nowrite[%0d] got %h want %h",
                         a, d, exp_mem[a]);
            end
        end
        pulse_start();
        checks++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL err_start err=%b busy=%b want 0 1", err, busy);
        end
        start      = 1'b1;
        conv_valid = 1'b1;
        conv_data  = $urandom;
        tick();
        start      = 1'b0;
        conv_valid = 1'b0;
        checks++;
        if (err !== 1'b0 || pass_idx !== '0) begin
            errors++;
            $display("FAIL coincident err=%b pass_idx=%0d want 0 0",
                     err, pass_idx);
        end
        for (int i = 0; i < NP * NPIX; i++) s.push_back($urandom);
        model_layer(s);
        for (int i = 0; i < s.size(); i++) send(s[i]);
        tick();
        for (int a = 0; a < NPIX; a++) begin
            read_word(a, d);
            checks++;
            if (d !== exp_mem[a]) begin
                errors++;
                $display("FAIL coincident_read[%0d] got %h want %h",
                         a, d, exp_mem[a]);
            end
        end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        send($urandom);
        checks++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL err_idle err=%b busy=%b want 1 0", err, busy);
        end
        pulse_start();
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_idle_clear err=%b want 0", err);
        end
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] d;
        pulse_start();
        for (int i = 0; i < NPIX + 2; i++) send($urandom | 32'h1);
        reset = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || rd_data !== '0) begin
            errors++;
            $display("FAIL mid_reset busy=%b done=%b rd_data=%h want 0 0 0",
                     busy, done, rd_data);
        end
        checks++;
        if (pass_idx !== '0 || err !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_cnt pass_idx=%0d err=%b want 0 0",
                     pass_idx, err);
        end
        tick();
        reset = 1'b1;
        tick();
        read_word(2, d);
        checks++;
        if (d !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_rd_ignored rd_data=%h busy=%b want 0 0",
                     d, busy);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_relu_signs();
        test_gaps();
        test_restart();
        test_err();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
